// File: rtl/maxpool_flatten_if.sv
// Handshake/bus bundle between the pooling stage, the conv-map BRAM and the feature BRAM.
interface maxpool_flatten_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_AW      = 13,
  parameter int OUT_AW     = 11
);
  logic                         start;
  logic [IN_AW-1:0]             in_addr;
  logic                         in_en;
  logic signed [DATA_WIDTH-1:0] in_q;
  logic [OUT_AW-1:0]            out_addr;
  logic                         out_we;
  logic signed [DATA_WIDTH-1:0] out_d;
  logic                         busy;
  logic                         done;

  modport master (
    input  start, in_q,
    output in_addr, in_en, out_addr, out_we, out_d, busy, done
  );
  modport slave (
    output start, in_q,
    input  in_addr, in_en, out_addr, out_we, out_d, busy, done
  );
endinterface

// File: rtl/maxpool_flatten.sv
// 2x2/stride-2 max-pool over a CHANNELS x IN_H x IN_W map, written out flattened channel-major.
module maxpool_flatten #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_H       = 28,
  parameter int IN_W       = 28,
  parameter int LAT        = 1
) (
  input  logic clk,
  input  logic reset_n,
  maxpool_flatten_if.master bus
);
  localparam int N_IN  = CHANNELS * IN_H * IN_W;
  localparam int N_OUT = N_IN / 4;
  localparam int IAW   = $clog2(N_IN);
  localparam int OAW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int HO    = IN_H / 2;
  localparam int WO    = IN_W / 2;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW    = (HO > 1) ? $clog2(HO) : 1;
  localparam int KW    = (WO > 1) ? $clog2(WO) : 1;
  localparam int LW    = (LAT > 1) ? $clog2(LAT) : 1;

  if ((IN_H % 2) != 0 || (IN_W % 2) != 0 || LAT < 1) begin : g_param_err
    $fatal(1, "maxpool_flatten: IN_H and IN_W must be even and LAT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CMP, S_WRITE, S_FINISH} state_t;

  state_t                       state_q;
  logic [CW-1:0]                c_q;
  logic [RW-1:0]                r_q;
  logic [KW-1:0]                col_q;
  logic [1:0]                   tap_q;
  logic [LW-1:0]                wait_q;
  logic [IAW-1:0]               base_q, in_addr_q;
  logic [OAW-1:0]               out_addr_q;
  logic signed [DATA_WIDTH-1:0] max_q, out_d_q, max_d;
  logic                         out_we_q, busy_q, done_q;
  logic [IAW-1:0]               tap_addr_d, base_d;
  logic                         col_last, row_last, ch_last;

  assign col_last = (col_q == KW'(WO - 1));
  assign row_last = (r_q == RW'(HO - 1));
  assign ch_last  = (c_q == CW'(CHANNELS - 1));

  always_comb begin
    max_d = max_q;
    if (tap_q == 2'd0 || bus.in_q > max_q) max_d = bus.in_q;
    case (tap_q)
      2'd0:    tap_addr_d = base_q + IAW'(1);
      2'd1:    tap_addr_d = base_q + IAW'(IN_W);
      default: tap_addr_d = base_q + IAW'(IN_W + 1);
    endcase
    // Stepping off the last window of a row pair (or of a channel) skips the odd row.
    base_d = col_last ? base_q + IAW'(IN_W + 2) : base_q + IAW'(2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      r_q        <= '0;
      col_q      <= '0;
      tap_q      <= '0;
      wait_q     <= '0;
      base_q     <= '0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      max_q      <= '0;
      out_d_q    <= '0;
      out_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      out_we_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          c_q        <= '0;
          r_q        <= '0;
          col_q      <= '0;
          tap_q      <= '0;
          base_q     <= '0;
          in_addr_q  <= '0;
          out_addr_q <= '0;
          busy_q     <= 1'b1;
          state_q    <= S_READ;
        end
        S_READ: begin
          wait_q  <= LW'(LAT - 1);
          state_q <= (LAT == 1) ? S_CMP : S_WAIT;
        end
        S_WAIT: begin
          wait_q <= wait_q - LW'(1);
          if (wait_q == LW'(1)) state_q <= S_CMP;
        end
        S_CMP: begin
          max_q <= max_d;
          if (tap_q == 2'd3) begin
            out_d_q  <= max_d;
            out_we_q <= 1'b1;
            state_q  <= S_WRITE;
          end else begin
            tap_q     <= tap_q + 2'd1;
            in_addr_q <= tap_addr_d;
            state_q   <= S_READ;
          end
        end
        S_WRITE: begin
          if (col_last && row_last && ch_last) begin
            state_q <= S_FINISH;
          end else begin
            tap_q      <= '0;
            base_q     <= base_d;
            in_addr_q  <= base_d;
            out_addr_q <= out_addr_q + OAW'(1);
            state_q    <= S_READ;
            if (!col_last) col_q <= col_q + KW'(1);
            else begin
              col_q <= '0;
              if (!row_last) r_q <= r_q + RW'(1);
              else begin
                r_q <= '0;
                c_q <= c_q + CW'(1);
              end
            end
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_en    = (state_q == S_READ);
  assign bus.in_addr  = in_addr_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_we   = out_we_q;
  assign bus.out_d    = out_d_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: doc/maxpool_flatten.md
Name: maxpool_flatten

Overview:
- Upstream neighbour of the fully-connected layer.
- Performs 2x2, stride-2 max-pooling over a CHANNELS x IN_H x IN_W signed feature map held in the conv-output BRAM.
- Writes the pooled map, flattened channel-major (c, row, col), into the feature BRAM that the dense layer reads as its input vector. Default 8x28x28 -> 1568 entries.
- One BRAM read per tap, sequenced by an FSM with the same LAT read-latency model the dense stage uses.

Parameters:
- DATA_WIDTH, 16, signed sample width.
- CHANNELS, 8, number of feature-map channels.
- IN_H, 28, input height; must be even.
- IN_W, 28, input width; must be even.
- LAT, 1, cycles from the in_en edge to valid in_q; must be >=1.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin pooling pass; sampled only in IDLE.
- in_addr  output  clog2(CHANNELS*IN_H*IN_W)  conv-map read address, c*IN_H*IN_W + y*IN_W + x.
- in_en  output  1  read strobe, combinationally high in READ.
- in_q  input  DATA_WIDTH signed  read data, valid LAT cycles after the in_en edge.
- out_addr  output  clog2(CHANNELS*IN_H*IN_W/4)  flattened write address.
- out_we  output  1  write strobe, one cycle per pooled value.
- out_d  output  DATA_WIDTH signed  pooled value.
- busy  output  1  high from the start edge until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous on reset_n low, mid-pass included.
  - State -> IDLE.
  - in_addr, out_addr, out_d, out_we, busy, done, counters and running max -> 0.
  - A partially written output buffer is left as-is; no further writes occur.
  - start is honoured on the first clock edge with reset_n high.
- Elaboration:
  - $fatal if IN_H or IN_W is odd, or LAT<1.
  - Output count N = CHANNELS*(IN_H/2)*(IN_W/2).
- States: IDLE, READ, WAIT, CMP, WRITE, FINISH.
- IDLE:
  - On start: clear c, r, col, tap; in_addr <= address of tap 0 of window (0,0,0); busy <= 1; -> READ.
  - start is ignored in every other state.
- READ:
  - in_en=1.
  - wait_cnt <= LAT-1.
  - -> CMP if LAT==1, else -> WAIT.
- WAIT: decrement wait_cnt; -> CMP when wait_cnt==0. This gives LAT-1 WAIT cycles.
- CMP: sample in_q.
  - tap 0: max <= in_q unconditionally.
  - taps 1-3: max <= in_q if in_q > max (signed compare); ties keep the existing value.
  - tap order: (dy,dx) = (0,0), (0,1), (1,0), (1,1).
  - Not last tap: tap++, in_addr <= next tap address, -> READ.
  - Last tap: -> WRITE.
- WRITE:
  - out_we=1 for this cycle; out_d = final max, including the tap-3 result; out_addr = c*(IN_H/2)*(IN_W/2) + r*(IN_W/2) + col.
  - out_addr is a running counter 0..N-1, incremented after each write; no wrap within a pass.
  - Advance col -> r -> c. Col wraps at IN_W/2 (r++); r wraps at IN_H/2 (c++).
  - Prime in_addr for the next window; -> READ.
  - After write N-1: -> FINISH.
- FINISH: done <= 1 (registered, visible the next cycle); busy <= 0; -> IDLE.
- Timing:
  - Per output: 4*(LAT+1)+1 cycles.
  - done is high exactly N*(4*(LAT+1)+1)+2 cycles after the edge that samples start.
- Write visibility:
  - The last pooled value is written before done rises.
  - The dense stage may be started on done.
- Back-to-back: start asserted in the same cycle done is high is accepted, since the FSM is in IDLE then. A new pass restarts at out_addr 0.
- Arithmetic:
  - Pure signed compare; no scaling, no saturation.
  - out_d is bit-exact to one of the four inputs.
  - Addresses are computed from incremental counters; no multipliers in the address path.

Test Plan:
- CHANNELS=1, IN_H=IN_W=4, LAT=1, map = 0..15 raster. Start -> writes 5, 7, 13, 15 at out_addr 0..3; 4 out_we pulses; done high 38 cycles after the start edge; busy low after.
- Same config, all samples negative with window (0,0) = {-3,-1,-7,-2}, a -32768 entry, and an all-equal -5 window. Out_d[0] = -1; equal window -> -5; -32768 never selected over a larger value.
- CHANNELS=2, IN_H=IN_W=4, LAT=2, distinct values per channel. Out_addr 0..3 hold channel-0 maxima, 4..7 channel-1; every in_addr matches c*16 + y*4 + x in tap order; done at 8*13+2 = 106 cycles.
- Default 8x28x28, LAT=1, random data vs reference model. 1568 writes, out_addr 0..1567 each written exactly once, all values match; done at 1568*9+2 cycles.
- Reset_n pulsed low mid-pass (after the 10th write) asynchronously, between edges. Outputs drop to 0 immediately, no further out_we; a subsequent start runs a full correct pass from out_addr 0.
- Start held high continuously for 3 passes. Start is ignored while busy; exactly 3 done pulses; each next pass begins the edge done is high.
